// File: rtl/rf_pkg.sv
// Shared types and default sizes for the parametrised register file.
package rf_pkg;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} rf_clr_state_t;

    localparam int RF_DATA_W_DEF = 4;
    localparam int RF_DEPTH_DEF  = 8;

endpackage

// File: rtl/rf_clear_seq.sv
// Run-time clear sequencer: walks every entry once, one per cycle, and
// pulses clr_done in the cycle after the last entry has been zeroed.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int  DEPTH  = RF_DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    // One spare counter bit lets the terminal index be compared directly.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    rf_clr_state_t   state_reg;
    logic [ADDR_W:0] count_reg;
    logic            busy_reg;
    logic            done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (clr_req) begin
                        state_reg <= CLEAR;
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                CLEAR: begin
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST_IDX) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign clr_done = done_reg;
    assign clr_we   = busy_reg;
    assign clr_addr = count_reg[ADDR_W-1:0];

endmodule

// File: rtl/param_register_file.sv
// Parametrised 2-read / 1-write register file with optional write bypass,
// optional hardwired-zero entry 0 and a run-time clear sequencer.
module param_register_file
    import rf_pkg::*;
#(
    parameter int  DATA_W   = RF_DATA_W_DEF,
    parameter int  DEPTH    = RF_DEPTH_DEF,
    parameter int  BYPASS   = 1,
    parameter int  ZERO_REG = 0,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] RF_add1,
    input  logic [ADDR_W-1:0] RF_add2,
    output logic [DATA_W-1:0] RF_d1,
    output logic [DATA_W-1:0] RF_d2,
    input  logic              RF_we,
    input  logic [ADDR_W-1:0] RF_wa,
    input  logic [DATA_W-1:0] RF_wd,
    output logic              RF_wr_ok,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done
);

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              zero_block;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_addr [2];

    rf_clear_seq #(
        .DEPTH(DEPTH)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign zero_block = (ZERO_REG != 0) && (RF_wa == '0);
    assign RF_wr_ok   = RF_we & ~busy & ~zero_block;

    // The clear sequencer owns the write port while it runs.
    always_comb begin
        wr_en   = clr_we | RF_wr_ok;
        wr_addr = RF_wa;
        wr_data = RF_wd;
        if (clr_we) begin
            wr_addr = clr_addr;
            wr_data = '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DATA_W-1:0] entry_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                    entry_reg <= wr_data;
                end
            end

            assign mem[gi] = entry_reg;
        end
    endgenerate

    assign rd_addr[0] = RF_add1;
    assign rd_addr[1] = RF_add2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] rd_val;

            // Priority: reset / hardwired zero, then bypass, then stored data.
            always_comb begin
                rd_val = mem[rd_addr[gi]];
                if ((BYPASS != 0) && RF_wr_ok && (rd_addr[gi] == RF_wa)) begin
                    rd_val = RF_wd;
                end
                if (!rst_n || ((ZERO_REG != 0) && (rd_addr[gi] == '0))) begin
                    rd_val = '0;
                end
            end
        end
    endgenerate

    assign RF_d1 = g_rd[0].rd_val;
    assign RF_d2 = g_rd[1].rd_val;

endmodule

// File: tb/tb_param_register_file.sv
// Drives two register-file configurations with shared stimulus and checks
// them each cycle against an array model plus directed expectations.
module tb_param_register_file;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic [3:0] a1;
    logic [3:0] a2;
    logic       clr;

    logic [7:0] a_d1, a_d2, b_d1, b_d2;
    logic       a_ok, a_busy, a_done, b_ok, b_busy, b_done;

    int n_checks = 0;
    int n_err    = 0;

    // dut_a: 16 x 8, bypass on, no zero register
    param_register_file #(
        .DATA_W(8), .DEPTH(16), .BYPASS(1), .ZERO_REG(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .RF_add1(a1), .RF_add2(a2), .RF_d1(a_d1), .RF_d2(a_d2),
        .RF_we(we), .RF_wa(wa), .RF_wd(wd), .RF_wr_ok(a_ok),
        .clr_req(clr), .busy(a_busy), .clr_done(a_done)
    );

    // dut_b: 8 x 8, bypass off, entry 0 hardwired to zero
    param_register_file #(
        .DATA_W(8), .DEPTH(8), .BYPASS(0), .ZERO_REG(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .RF_add1(a1[2:0]), .RF_add2(a2[2:0]), .RF_d1(b_d1), .RF_d2(b_d2),
        .RF_we(we), .RF_wa(wa[2:0]), .RF_wd(wd), .RF_wr_ok(b_ok),
        .clr_req(clr), .busy(b_busy), .clr_done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] o_d1 [2];
    logic [7:0] o_d2 [2];
    logic [1:0] o_ok, o_busy, o_done;
    assign o_d1[0] = a_d1;
    assign o_d1[1] = b_d1;
    assign o_d2[0] = a_d2;
    assign o_d2[1] = b_d2;
    assign o_ok    = {b_ok, a_ok};
    assign o_busy  = {b_busy, a_busy};
    assign o_done  = {b_done, a_done};

    // Reference model: contents, and the cycle on which each clear began.
    logic [7:0] mem [2][16];
    int         clr_start [2];
    int         cyc = 0;

    logic [7:0] last_d1 [2];
    logic [7:0] last_d2 [2];
    logic [1:0] last_ok, last_busy, last_done;

    function automatic int depth_of(input int d);
        return (d == 0) ? 16 : 8;
    endfunction

    function automatic int amask(input int d, input logic [3:0] a);
        return (d == 0) ? int'(a) : int'(a) % 8;
    endfunction

    function automatic bit m_busy(input int d);
        return clr_start[d] >= 0 && cyc >= clr_start[d] && cyc < clr_start[d] + depth_of(d);
    endfunction

    function automatic bit m_done(input int d);
        return clr_start[d] >= 0 && cyc == clr_start[d] + depth_of(d);
    endfunction

    function automatic bit m_wr_ok(input int d);
        return we && !m_busy(d) && !(d == 1 && amask(d, wa) == 0);
    endfunction

    function automatic logic [7:0] m_read(input int d, input logic [3:0] a);
        int ad = amask(d, a);
        if (d == 1 && ad == 0) return 8'h00;
        if (d == 0 && m_wr_ok(d) && ad == amask(d, wa)) return wd;
        return mem[d][ad];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) mem[d][i] = 8'h00;
            clr_start[d] = -1000;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check combinational outputs, then advance the model.
    task automatic step(input logic we_i, input logic [3:0] wa_i, input logic [7:0] wd_i,
                        input logic [3:0] a1_i, input logic [3:0] a2_i, input logic clr_i);
        we  = we_i;
        wa  = wa_i;
        wd  = wd_i;
        a1  = a1_i;
        a2  = a2_i;
        clr = clr_i;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_rd1 c%0d", d, cyc), 32'(o_d1[d]), 32'(m_read(d, a1)));
            check($sformatf("d%0d_rd2 c%0d", d, cyc), 32'(o_d2[d]), 32'(m_read(d, a2)));
            check($sformatf("d%0d_wr_ok c%0d", d, cyc), 32'(o_ok[d]), 32'(m_wr_ok(d)));
            check($sformatf("d%0d_busy c%0d", d, cyc), 32'(o_busy[d]), 32'(m_busy(d)));
            check($sformatf("d%0d_done c%0d", d, cyc), 32'(o_done[d]), 32'(m_done(d)));
            last_d1[d]   = o_d1[d];
            last_d2[d]   = o_d2[d];
            last_ok[d]   = o_ok[d];
            last_busy[d] = o_busy[d];
            last_done[d] = o_done[d];
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (m_busy(d)) mem[d][cyc - clr_start[d]] = 8'h00;
            else if (m_wr_ok(d)) mem[d][amask(d, wa)] = wd;
            if (!m_busy(d) && !m_done(d) && clr) clr_start[d] = cyc + 1;
        end
        cyc++;
        @(negedge clk);
    endtask

    // While reset is held every address on both ports must read zero.
    task automatic scan_zero(input string tag);
        we  = 1'b0;
        clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a1 = 4'(i);
            a2 = 4'(15 - i);
            #1;
            check({tag, "_a_d1"}, 32'(a_d1), 32'h0);
            check({tag, "_a_d2"}, 32'(a_d2), 32'h0);
            check({tag, "_b_d1"}, 32'(b_d1), 32'h0);
            check({tag, "_b_d2"}, 32'(b_d2), 32'h0);
        end
        check({tag, "_busy"}, 32'(o_busy), 32'h0);
        check({tag, "_done"}, 32'(o_done), 32'h0);
    endtask

    int busy_cnt [2];
    int done_cnt [2];

    initial begin
        rst_n = 1'b0;
        we = 1'b0; wa = '0; wd = '0; a1 = '0; a2 = '0; clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset with random prior contents
        for (int i = 0; i < 20; i++)
            step(1'b1, 4'($urandom), 8'($urandom), 4'($urandom), 4'($urandom), 1'b0);
        rst_n = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            scan_zero("reset_hold");
            @(negedge clk);
        end
        rst_n = 1'b1;

        // Write / read
        step(1'b1, 4'd3, 8'hA5, 4'd0, 4'd0, 1'b0);
        step(1'b1, 4'd15, 8'h3C, 4'd0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 8'h00, 4'd3, 4'd15, 1'b0);
        check("wr_rd_a_d1", 32'(last_d1[0]), 32'hA5);
        check("wr_rd_a_d2", 32'(last_d2[0]), 32'h3C);
        step(1'b0, 4'd0, 8'h00, 4'd3, 4'd3, 1'b0);
        check("wr_rd_hold", 32'(last_d1[0]), 32'hA5);

        // Bypass (dut_a) versus no bypass (dut_b)
        step(1'b1, 4'd5, 8'h07, 4'd5, 4'd5, 1'b0);
        check("bypass_on", 32'(last_d1[0]), 32'h07);
        check("bypass_off", 32'(last_d1[1]), 32'h00);
        step(1'b0, 4'd0, 8'h00, 4'd5, 4'd5, 1'b0);
        check("bypass_off_next", 32'(last_d1[1]), 32'h07);

        // Clear sequence with a blocked write mid-clear
        for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 8'h0F, 4'(i), 4'(i), 1'b0);
        step(1'b0, 4'd0, 8'h00, 4'd6, 4'd6, 1'b1);
        check("clr_start_busy", 32'(last_busy), 32'h0);
        busy_cnt = '{0, 0};
        done_cnt = '{0, 0};
        for (int k = 0; k < 20; k++) begin
            if (k == 4) begin
                step(1'b1, 4'd2, 8'h55, 4'd2, 4'd2, 1'b0);
                check("clr_blocked_wr_b", 32'(last_ok[1]), 32'h0);
                check("clr_blocked_wr_a", 32'(last_ok[0]), 32'h0);
            end else begin
                step(1'b0, 4'd0, 8'h00, 4'(k), 4'(k), 1'b0);
            end
            for (int d = 0; d < 2; d++) begin
                busy_cnt[d] += int'(last_busy[d]);
                done_cnt[d] += int'(last_done[d]);
            end
        end
        check("clr_busy_cycles_a", 32'(busy_cnt[0]), 32'd16);
        check("clr_busy_cycles_b", 32'(busy_cnt[1]), 32'd8);
        check("clr_done_pulses_a", 32'(done_cnt[0]), 32'd1);
        check("clr_done_pulses_b", 32'(done_cnt[1]), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 4'd0, 8'h00, 4'(i), 4'(i), 1'b0);
            check("clr_after_a", 32'(last_d1[0]), 32'h0);
            check("clr_after_b", 32'(last_d1[1]), 32'h0);
        end

        // Hardwired zero entry on dut_b
        step(1'b1, 4'd0, 8'h09, 4'd0, 4'd0, 1'b0);
        check("zreg_wr_ok_b", 32'(last_ok[1]), 32'h0);
        check("zreg_wr_ok_a", 32'(last_ok[0]), 32'h1);
        check("zreg_rd_b", 32'(last_d1[1]), 32'h0);
        step(1'b1, 4'd1, 8'h09, 4'd0, 4'd0, 1'b0);
        check("zreg_rd_b_next", 32'(last_d1[1]), 32'h0);
        check("zreg_wr1_ok_b", 32'(last_ok[1]), 32'h1);
        step(1'b0, 4'd0, 8'h00, 4'd1, 4'd0, 1'b0);
        check("zreg_rd1_b", 32'(last_d1[1]), 32'h09);

        // Reset in the middle of a clear
        step(1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 4'd0, 8'h00, 4'd1, 4'd1, 1'b0);
        check("midclr_busy_before", 32'(last_busy), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("midclr_busy_async", 32'(o_busy), 32'h0);
        model_reset();
        for (int k = 0; k < 2; k++) begin
            scan_zero("midclr_hold");
            @(negedge clk);
        end
        rst_n = 1'b1;
        step(1'b0, 4'd0, 8'h00, 4'd1, 4'd1, 1'b0);
        check("midclr_no_done", 32'(last_done), 32'h0);
        step(1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b1);
        done_cnt = '{0, 0};
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 4'd0, 8'h00, 4'($urandom), 4'($urandom), 1'b0);
            for (int d = 0; d < 2; d++) done_cnt[d] += int'(last_done[d]);
        end
        check("midclr_reclear_a", 32'(done_cnt[0]), 32'd1);
        check("midclr_reclear_b", 32'(done_cnt[1]), 32'd1);

        // Random traffic with occasional clears
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, 4'($urandom), 8'($urandom),
                 4'($urandom), 4'($urandom), $urandom_range(0, 29) == 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised successor to the team's fixed 8x4 register file.
- Configurable data width and depth, two asynchronous read ports and one synchronous write port.
- Optional write-to-read bypass and optional hardwired-zero register 0.
- Run-time "clear all" sequencer that zeroes the array one entry per cycle, with a busy/done handshake. Sits beside the datapath ALU as its operand store.

Parameters:
- DATA_W, 4: width of each entry in bits (1..32).
- DEPTH, 8: number of entries; power of two, 2..64.
- ADDR_W, $clog2(DEPTH): address width; derived, not overridden.
- BYPASS, 1: 1 = a read of the address being written this cycle returns RF_wd; 0 = returns the old contents.
- ZERO_REG, 0: 1 = entry 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- RF_add1  in  ADDR_W  read address, port 1
- RF_add2  in  ADDR_W  read address, port 2
- RF_d1  out  DATA_W  read data, port 1 (combinational)
- RF_d2  out  DATA_W  read data, port 2 (combinational)
- RF_we  in  1  write enable
- RF_wa  in  ADDR_W  write address
- RF_wd  in  DATA_W  write data
- RF_wr_ok  out  1  write accepted this cycle (comb: RF_we & ~busy & ~(ZERO_REG & RF_wa==0))
- clr_req  in  1  request run-time clear; sampled high for one or more cycles
- busy  out  1  clear sequence in progress
- clr_done  out  1  one-cycle pulse in the cycle after the last entry is cleared

Behaviour:
- Reset (rst_n low, asynchronous):
  - All entries are set to 0.
  - FSM goes to IDLE, clear counter to 0.
  - busy=0, clr_done=0.
  - RF_d1/RF_d2 read 0 while reset is held.
- Reads:
  - Combinational, zero latency: RF_dN = data[RF_addN].
  - When BYPASS=1, RF_wr_ok=1 and RF_addN==RF_wa, RF_dN = RF_wd in the same cycle.
  - When ZERO_REG=1 and RF_addN==0, RF_dN = 0 regardless of the other rules.
  - Both ports may read the same address.
- Writes:
  - On the posedge where RF_wr_ok=1, data[RF_wa] <= RF_wd.
  - Nonblocking updates; new value visible on reads from the next cycle (or same cycle via bypass).
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_req=1 at a posedge -> CLEAR, counter <= 0.
  - CLEAR: busy=1. Each posedge: data[counter] <= 0, counter++. At the posedge that clears entry DEPTH-1 -> DONE. Takes exactly DEPTH cycles.
  - DONE: busy=0, clr_done=1 for one cycle, then -> IDLE unconditionally. clr_req in DONE is ignored; a fresh request is needed in IDLE.
  - clr_req while in CLEAR is ignored; the sequence is not restarted.
- Writes during busy:
  - Writes are dropped and RF_wr_ok=0. The upstream must hold or retry.
  - Reads stay legal. An entry returns 0 once cleared and its old value until then.
  - Bypass is inactive while busy, because RF_wr_ok=0.
- Write in the same cycle as clr_req accepted in IDLE: the write commits (busy is still 0 that cycle), then the clear sequence zeroes it.
- Counter is ADDR_W+1 bits wide, so the terminal compare needs no wrap-around special case.
- rst_n asserted mid-clear: immediate return to IDLE with the array zeroed; no clr_done pulse.
- Out-of-range addresses cannot occur because DEPTH is a power of two.

Decomposition:
- Package rf_pkg holds:
  - typedef enum logic [1:0] {IDLE, CLEAR, DONE} rf_clr_state_t
  - default constants RF_DATA_W_DEF=4 and RF_DEPTH_DEF=8
- Sub-module rf_clear_seq:
  - Contains the FSM and counter; parameter DEPTH.
  - Ports: clk, rst_n, clr_req, busy, clr_done, clr_we, clr_addr.
- Top level muxes clr_we/clr_addr onto the array write port and holds the storage, read, bypass and ZERO_REG logic.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with random prior contents -> RF_d1/RF_d2 = 0 for every address, busy=0, clr_done=0.
2. Write/read, DATA_W=8, DEPTH=16: write 0xA5 to addr 3, then 0x3C to addr 15, then read (3,15) -> RF_d1=0xA5, RF_d2=0x3C. Next cycle, with RF_we=0, addr 3 still reads 0xA5.
3. Bypass: BYPASS=1, write 0x7 to addr 5 while RF_add1=5 -> RF_d1=0x7 in the same cycle. Repeat with BYPASS=0 -> RF_d1 shows the old value 0x0 that cycle and 0x7 the next.
4. Clear: fill all 8 entries with 0xF, pulse clr_req -> busy=1 for exactly 8 cycles, clr_done high for 1 cycle, all entries then read 0. A write to addr 2 at busy cycle 4 gives RF_wr_ok=0 and addr 2 reads 0 afterwards.
5. ZERO_REG=1: write 0x9 to addr 0 -> RF_wr_ok=0 and RF_d1(addr 0)=0. A write of 0x9 to addr 1 succeeds.
6. Reset mid-clear: assert rst_n=0 at CLEAR cycle 3 -> busy drops asynchronously, no clr_done pulse, all entries read 0. After release, a new clr_req completes normally.
